// File: rtl/dsp_pkg.sv
// Shared constants and saturation-limit helpers for the streaming MAC.
package dsp_pkg;

  localparam int PIPE_DEPTH     = 4;
  localparam int OPERAND_STAGES = PIPE_DEPTH - 2;

  // Range limits returned as 64-bit patterns; callers truncate to their width.
  function automatic logic [63:0] sat_max(input int width, input bit is_signed);
    return is_signed ? (64'd1 << (width - 1)) - 64'd1 : (64'd1 << width) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width, input bit is_signed);
    return is_signed ? (64'd1 << (width - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/dsp_mac_acc.sv
// S4 accumulator: sums products over a vector, detects overflow per beat and
// keeps a sticky overflow flag that restarts with each vector's first beat.
module dsp_mac_acc
  import dsp_pkg::*;
#(
  parameter int PW       = 16,
  parameter int AW       = 24,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] product,
  input  logic          valid,
  input  logic          last,
  input  logic          en,
  output logic [AW-1:0] sum,
  output logic          ovf,
  output logic          done
);

  localparam logic [AW-1:0] MAX_VAL = AW'(sat_max(AW, SIGNED));
  localparam logic [AW-1:0] MIN_VAL = AW'(sat_min(AW, SIGNED));

  logic          first_beat;
  logic [AW-1:0] base;
  logic [AW-1:0] p_ext;
  logic [AW:0]   wide;
  logic          over;
  logic [AW-1:0] result;

  always_comb begin
    base   = first_beat ? '0 : sum;
    p_ext  = '0;
    wide   = '0;
    over   = 1'b0;
    if (SIGNED) begin
      p_ext = AW'($signed(product));
      wide  = {base[AW-1], base} + {p_ext[AW-1], p_ext};
      over  = wide[AW] ^ wide[AW-1];
    end else begin
      p_ext = AW'(product);
      wide  = {1'b0, base} + {1'b0, p_ext};
      over  = wide[AW];
    end
    result = wide[AW-1:0];
    // wide[AW] holds the true sign, which picks the clamp direction
    if (SATURATE && over) begin
      if (SIGNED) result = wide[AW] ? MIN_VAL : MAX_VAL;
      else        result = MAX_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum        <= '0;
      ovf        <= 1'b0;
      done       <= 1'b0;
      first_beat <= 1'b1;
    end else if (en) begin
      done <= valid & last;
      if (valid) begin
        sum        <= result;
        ovf        <= (first_beat ? 1'b0 : ovf) | over;
        first_beat <= last;
      end
    end
  end

endmodule

// File: rtl/dsp_mac_stream.sv
// Streaming multiply-accumulate: joins weight/activation streams, multiplies in a
// registered chain and emits one accumulated sum per tlast-framed vector.
module dsp_mac_stream
  import dsp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter bit SIGNED    = 1'b1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     input_a_tdata,
  input  logic                 input_a_tvalid,
  output logic                 input_a_tready,
  input  logic                 input_a_tlast,
  input  logic [WIDTH-1:0]     input_b_tdata,
  input  logic                 input_b_tvalid,
  output logic                 input_b_tready,
  output logic [ACC_WIDTH-1:0] output_tdata,
  output logic                 output_tvalid,
  input  logic                 output_tready,
  output logic                 output_tuser
);

  localparam int PW = 2 * WIDTH;

  logic en;
  logic xfer;

  logic [WIDTH-1:0] op_a    [OPERAND_STAGES];
  logic [WIDTH-1:0] op_b    [OPERAND_STAGES];
  logic             op_valid[OPERAND_STAGES];
  logic             op_last [OPERAND_STAGES];

  logic [PW-1:0]    mult;
  logic [PW-1:0]    prod;
  logic             prod_valid;
  logic             prod_last;

  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 acc_ovf;
  logic                 acc_done;

  // The whole pipe stalls as one unit, so a single enable covers every stage.
  assign en             = ~output_tvalid | output_tready;
  assign xfer           = input_a_tvalid & input_b_tvalid & en;
  assign input_a_tready = input_b_tvalid & en;
  assign input_b_tready = input_a_tvalid & en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OPERAND_STAGES; i++) begin
        op_a[i]     <= '0;
        op_b[i]     <= '0;
        op_valid[i] <= 1'b0;
        op_last[i]  <= 1'b0;
      end
    end else if (en) begin
      op_a[0]     <= input_a_tdata;
      op_b[0]     <= input_b_tdata;
      op_valid[0] <= xfer;
      op_last[0]  <= input_a_tlast;
      for (int i = 1; i < OPERAND_STAGES; i++) begin
        op_a[i]     <= op_a[i-1];
        op_b[i]     <= op_b[i-1];
        op_valid[i] <= op_valid[i-1];
        op_last[i]  <= op_last[i-1];
      end
    end
  end

  always_comb begin
    if (SIGNED) mult = PW'($signed(op_a[OPERAND_STAGES-1])) * PW'($signed(op_b[OPERAND_STAGES-1]));
    else        mult = PW'(op_a[OPERAND_STAGES-1]) * PW'(op_b[OPERAND_STAGES-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
    end else if (en) begin
      prod       <= mult;
      prod_valid <= op_valid[OPERAND_STAGES-1];
      prod_last  <= op_last[OPERAND_STAGES-1];
    end
  end

  dsp_mac_acc #(
    .PW       (PW),
    .AW       (ACC_WIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .product (prod),
    .valid   (prod_valid),
    .last    (prod_last),
    .en      (en),
    .sum     (acc_sum),
    .ovf     (acc_ovf),
    .done    (acc_done)
  );

  // A new sum may replace one being accepted in the same cycle without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_tdata  <= '0;
      output_tuser  <= 1'b0;
      output_tvalid <= 1'b0;
    end else if (en) begin
      if (acc_done) begin
        output_tdata  <= acc_sum;
        output_tuser  <= acc_ovf;
        output_tvalid <= 1'b1;
      end else begin
        output_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_stream.sv
// Directed bench: four parameterisations share the input streams and each
// instance's accepted sums are collected for in-order comparison.
module tb_dsp_mac_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_last;
  logic       out_ready;

  logic        m_ar, m_br, m_valid, m_user;
  logic [23:0] m_data;
  logic        s_ar, s_br, s_valid, s_user;
  logic [15:0] s_data;
  logic        w_ar, w_br, w_valid, w_user;
  logic [15:0] w_data;
  logic        u_ar, u_br, u_valid, u_user;
  logic [23:0] u_data;

  int checks   = 0;
  int failures = 0;

  logic [23:0] q_m[$];
  logic        qu_m[$];
  logic [15:0] q_s[$];
  logic        qu_s[$];
  logic [15:0] q_w[$];
  logic        qu_w[$];
  logic [23:0] q_u[$];
  logic        qu_u[$];

  always #5 clk = ~clk;

  dsp_mac_stream #(.WIDTH(8), .ACC_WIDTH(24), .SIGNED(1'b1), .SATURATE(1'b0)) dut_main (
    .clk(clk), .rst(rst),
    .input_a_tdata(a_data), .input_a_tvalid(a_valid), .input_a_tready(m_ar), .input_a_tlast(a_last),
    .input_b_tdata(b_data), .input_b_tvalid(b_valid), .input_b_tready(m_br),
    .output_tdata(m_data), .output_tvalid(m_valid), .output_tready(out_ready), .output_tuser(m_user));

  dsp_mac_stream #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst),
    .input_a_tdata(a_data), .input_a_tvalid(a_valid), .input_a_tready(s_ar), .input_a_tlast(a_last),
    .input_b_tdata(b_data), .input_b_tvalid(b_valid), .input_b_tready(s_br),
    .output_tdata(s_data), .output_tvalid(s_valid), .output_tready(out_ready), .output_tuser(s_user));

  dsp_mac_stream #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst),
    .input_a_tdata(a_data), .input_a_tvalid(a_valid), .input_a_tready(w_ar), .input_a_tlast(a_last),
    .input_b_tdata(b_data), .input_b_tvalid(b_valid), .input_b_tready(w_br),
    .output_tdata(w_data), .output_tvalid(w_valid), .output_tready(out_ready), .output_tuser(w_user));

  dsp_mac_stream #(.WIDTH(8), .ACC_WIDTH(24), .SIGNED(1'b0), .SATURATE(1'b0)) dut_uns (
    .clk(clk), .rst(rst),
    .input_a_tdata(a_data), .input_a_tvalid(a_valid), .input_a_tready(u_ar), .input_a_tlast(a_last),
    .input_b_tdata(b_data), .input_b_tvalid(b_valid), .input_b_tready(u_br),
    .output_tdata(u_data), .output_tvalid(u_valid), .output_tready(out_ready), .output_tuser(u_user));

  always @(posedge clk) begin
    if (out_ready) begin
      if (m_valid) begin q_m.push_back(m_data); qu_m.push_back(m_user); end
      if (s_valid) begin q_s.push_back(s_data); qu_s.push_back(s_user); end
      if (w_valid) begin q_w.push_back(w_data); qu_w.push_back(w_user); end
      if (u_valid) begin q_u.push_back(u_data); qu_u.push_back(u_user); end
    end
  end

  task automatic clear_queues();
    q_m.delete(); qu_m.delete(); q_s.delete(); qu_s.delete();
    q_w.delete(); qu_w.delete(); q_u.delete(); qu_u.delete();
  endtask

  // Presents one beat on both streams and returns once it has been accepted.
  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic last,
                            output int cycles);
    logic taken;
    a_data = a; b_data = b; a_last = last; a_valid = 1'b1; b_valid = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      taken = m_ar & m_br;
      @(posedge clk); #1;
      cycles++;
    end while (!taken && cycles < 50);
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic wait_outs(input int n, output bit ok);
    int k = 0;
    while (q_m.size() < n && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (q_m.size() >= n);
  endtask

  task automatic test_reset();
    int cyc;
    int lat;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 24'h0 || m_user !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%h user=%b required 0/000000/0", m_valid, m_data, m_user);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive_beat(8'd5, 8'd5, 1'b0, cyc);
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 24'h0) begin
      failures++;
      $display("FAIL reset_mid_vector: valid=%b data=%h required 0/000000", m_valid, m_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_queues();
    drive_beat(8'd2, 8'd3, 1'b1, cyc);
    lat = 0;
    while (m_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL reset_latency: cycles=%0d required 4", lat);
    end
    checks++;
    if (m_data !== 24'd6 || m_user !== 1'b0) begin
      failures++;
      $display("FAIL reset_result: data=%0d user=%b required 6/0", m_data, m_user);
    end
    $display("reset: partial vector discarded, 2*3 -> %0d after %0d cycles", m_data, lat);
    repeat (2) @(posedge clk);
    #1;
    clear_queues();
  endtask

  task automatic test_dot_product();
    logic [7:0] va[4];
    logic [7:0] vb[4];
    int cyc;
    int total = 0;
    bit ok;
    va = '{8'd1, 8'hFE, 8'd3, 8'd4};
    vb = '{8'd5, 8'd6, 8'hF9, 8'd8};
    clear_queues();
    for (int i = 0; i < 4; i++) begin
      drive_beat(va[i], vb[i], i == 3, cyc);
      total += cyc;
    end
    checks++;
    if (total != 4) begin
      failures++;
      $display("FAIL dot_throughput: cycles=%0d required 4", total);
    end
    wait_outs(1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL dot_timeout: outputs=%0d required 1", q_m.size());
    end else begin
      checks++;
      if (q_m[0] !== 24'h000004 || qu_m[0] !== 1'b0) begin
        failures++;
        $display("FAIL dot_result: data=%h user=%b required 000004/0", q_m[0], qu_m[0]);
      end
      $display("dot_product: {1,-2,3,4}.{5,6,-7,8} -> %0d user=%b", $signed(q_m[0]), qu_m[0]);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int k;
    bit ok;
    clear_queues();
    drive_beat(8'd1, 8'd1, 1'b0, cyc);
    drive_beat(8'd2, 8'd2, 1'b1, cyc);
    drive_beat(8'd3, 8'd3, 1'b1, cyc);
    k = 0;
    while (m_valid !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0;
    a_data = 8'd4; b_data = 8'd4; a_last = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (m_ar !== 1'b0 || m_br !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready: cycle=%0d a_ready=%b b_ready=%b required 0/0", i, m_ar, m_br);
      end
      checks++;
      if (m_valid !== 1'b1 || m_data !== 24'd5) begin
        failures++;
        $display("FAIL stall_hold: cycle=%0d valid=%b data=%0d required 1/5", i, m_valid, m_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_ar !== 1'b1) begin
      failures++;
      $display("FAIL release_ready: a_ready=%b required 1", m_ar);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 24'd9) begin
      failures++;
      $display("FAIL accept_and_load: valid=%b data=%0d required 1/9", m_valid, m_data);
    end
    wait_outs(3, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL backpressure_timeout: outputs=%0d required 3", q_m.size());
    end else begin
      checks++;
      if (q_m.size() != 3 || q_m[0] !== 24'd5 || q_m[1] !== 24'd9 || q_m[2] !== 24'd16) begin
        failures++;
        $display("FAIL backpressure_seq: n=%0d got %0d,%0d,%0d required 5,9,16",
                 q_m.size(), q_m[0], q_m[1], q_m[2]);
      end
      $display("backpressure: sums %0d %0d %0d", q_m[0], q_m[1], q_m[2]);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    bit ok;
    clear_queues();
    for (int i = 0; i < 4; i++) drive_beat(8'h80, 8'h80, i == 3, cyc);
    wait_outs(1, ok);
    checks++;
    if (!ok || q_s.size() < 1 || q_w.size() < 1) begin
      failures++;
      $display("FAIL sat_timeout: outputs=%0d/%0d/%0d required 1", q_m.size(), q_s.size(), q_w.size());
    end else begin
      checks++;
      if (q_s[0] !== 16'h7FFF || qu_s[0] !== 1'b1) begin
        failures++;
        $display("FAIL sat_clamp: data=%h user=%b required 7fff/1", q_s[0], qu_s[0]);
      end
      checks++;
      if (q_w[0] !== 16'h0000 || qu_w[0] !== 1'b1) begin
        failures++;
        $display("FAIL sat_wrap: data=%h user=%b required 0000/1", q_w[0], qu_w[0]);
      end
      checks++;
      if (q_m[0] !== 24'h010000 || qu_m[0] !== 1'b0) begin
        failures++;
        $display("FAIL wide_no_ovf: data=%h user=%b required 010000/0", q_m[0], qu_m[0]);
      end
      $display("saturation: sat=%h/%b wrap=%h/%b wide=%h/%b",
               q_s[0], qu_s[0], q_w[0], qu_w[0], q_m[0], qu_m[0]);
    end
  endtask

  task automatic test_unsigned();
    int cyc;
    bit ok;
    clear_queues();
    drive_beat(8'hFF, 8'hFF, 1'b0, cyc);
    drive_beat(8'hFF, 8'hFF, 1'b1, cyc);
    wait_outs(1, ok);
    checks++;
    if (!ok || q_u.size() < 1) begin
      failures++;
      $display("FAIL unsigned_timeout: outputs=%0d required 1", q_u.size());
    end else begin
      checks++;
      if (q_u[0] !== 24'h01FC02 || qu_u[0] !== 1'b0) begin
        failures++;
        $display("FAIL unsigned_result: data=%h user=%b required 01fc02/0", q_u[0], qu_u[0]);
      end
      checks++;
      if (q_m[0] !== 24'd2) begin
        failures++;
        $display("FAIL signed_minus_one: data=%h required 000002", q_m[0]);
      end
      $display("unsigned: 255*255*2 -> %h, signed view -> %h", q_u[0], q_m[0]);
    end
  endtask

  task automatic test_valid_skew();
    logic signed [7:0] va[4];
    logic signed [7:0] vb[4];
    int idx = 0;
    int cyc = 0;
    int model = 0;
    logic taken;
    logic [23:0] exp_sum;
    bit ok;
    va = '{8'sd3, -8'sd4, 8'sd5, 8'sd7};
    vb = '{8'sd2, 8'sd6, -8'sd1, 8'sd10};
    for (int i = 0; i < 4; i++) model += int'(va[i]) * int'(vb[i]);
    exp_sum = 24'(model);
    clear_queues();
    a_valid = 1'b1;
    while (idx < 4 && cyc < 40) begin
      a_data = va[idx]; b_data = vb[idx]; a_last = (idx == 3);
      b_valid = (cyc % 2 == 0);
      @(negedge clk);
      if (!b_valid) begin
        checks++;
        if (m_ar !== 1'b0 || m_br !== 1'b1) begin
          failures++;
          $display("FAIL skew_ready: cycle=%0d a_ready=%b b_ready=%b required 0/1", cyc, m_ar, m_br);
        end
      end
      taken = m_ar & m_br;
      @(posedge clk); #1;
      cyc++;
      if (taken) idx++;
    end
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0;
    checks++;
    if (cyc != 7) begin
      failures++;
      $display("FAIL skew_throughput: cycles=%0d required 7", cyc);
    end
    wait_outs(1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL skew_timeout: outputs=%0d required 1", q_m.size());
    end else begin
      checks++;
      if (q_m[0] !== exp_sum || qu_m[0] !== 1'b0) begin
        failures++;
        $display("FAIL skew_result: data=%h user=%b required %h/0", q_m[0], qu_m[0], exp_sum);
      end
      $display("valid_skew: 4 beats in %0d cycles, sum %0d", cyc, $signed(q_m[0]));
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0;
    test_reset();
    test_dot_product();
    test_backpressure();
    test_saturation();
    test_unsigned();
    test_valid_skew();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
